// File: rtl/axi_arb_pkg.sv
// Shared types and constants for the AXI read arbiter.
package axi_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADDR = 2'd1,
        DATA = 2'd2
    } arb_state_t;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first request at or after i_ptr, wrapping.
module rr_arbiter #(
    parameter int unsigned NUM_MST = 4,
    parameter int unsigned IDX_W   = $clog2(NUM_MST)
) (
    input  logic [NUM_MST-1:0] i_req,
    input  logic [IDX_W-1:0]   i_ptr,
    output logic [NUM_MST-1:0] o_grant,
    output logic [IDX_W-1:0]   o_idx
);

    always_comb begin
        o_grant = '0;
        o_idx   = '0;
        // Offset k walks i_ptr, i_ptr+1, ... so the first hit is the winner
        for (int unsigned k = 0; k < NUM_MST; k++) begin
            for (int unsigned j = 0; j < NUM_MST; j++) begin
                if ((o_grant == '0) && i_req[j] && (j == (32'(i_ptr) + k) % NUM_MST)) begin
                    o_grant[j] = 1'b1;
                    o_idx      = IDX_W'(j);
                end
            end
        end
    end

endmodule

// File: rtl/axi_rd_arbiter.sv
// Round-robin arbiter sharing one downstream AXI read port between NUM_MST masters,
// one burst at a time, with sticky RID-index and RLAST-position error flags.
module axi_rd_arbiter #(
    parameter int unsigned NUM_MST    = 4,
    parameter int unsigned ID_WIDTH   = 4,
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned LEN_WIDTH  = 8,
    parameter int unsigned IDX_W      = $clog2(NUM_MST)
) (
    input  logic                            ACLK,
    input  logic                            ARESETn,
    input  logic [NUM_MST-1:0]              s_arvalid,
    output logic [NUM_MST-1:0]              s_arready,
    input  logic [NUM_MST*ID_WIDTH-1:0]     s_arid,
    input  logic [NUM_MST*ADDR_WIDTH-1:0]   s_araddr,
    input  logic [NUM_MST*LEN_WIDTH-1:0]    s_arlen,
    input  logic [NUM_MST*3-1:0]            s_arsize,
    input  logic [NUM_MST*2-1:0]            s_arburst,
    output logic [NUM_MST-1:0]              s_rvalid,
    input  logic [NUM_MST-1:0]              s_rready,
    output logic [ID_WIDTH-1:0]             s_rid,
    output logic [DATA_WIDTH-1:0]           s_rdata,
    output logic [1:0]                      s_rresp,
    output logic                            s_rlast,
    output logic                            m_arvalid,
    input  logic                            m_arready,
    output logic [ID_WIDTH+IDX_W-1:0]       m_arid,
    output logic [ADDR_WIDTH-1:0]           m_araddr,
    output logic [LEN_WIDTH-1:0]            m_arlen,
    output logic [2:0]                      m_arsize,
    output logic [1:0]                      m_arburst,
    input  logic                            m_rvalid,
    output logic                            m_rready,
    input  logic [ID_WIDTH+IDX_W-1:0]       m_rid,
    input  logic [DATA_WIDTH-1:0]           m_rdata,
    input  logic [1:0]                      m_rresp,
    input  logic                            m_rlast,
    output logic                            busy,
    output logic [IDX_W-1:0]                grant_idx,
    output logic                            err_id,
    output logic                            err_len
);

    import axi_arb_pkg::*;

    arb_state_t             r_state, w_state_nxt;
    logic [IDX_W-1:0]       r_rr_ptr, r_grant_idx, w_arb_idx, w_ptr_nxt;
    logic [NUM_MST-1:0]     w_arb_onehot;
    logic                   w_arb_any;
    logic [LEN_WIDTH:0]     r_beat_cnt;
    logic [LEN_WIDTH-1:0]   r_exp_len;
    logic                   r_err_id, r_err_len;
    logic [ID_WIDTH-1:0]    w_g_arid;
    logic                   w_g_rready;
    logic                   w_ar_hs, w_r_hs;

    rr_arbiter #(
        .NUM_MST (NUM_MST),
        .IDX_W   (IDX_W)
    ) u_rr_arbiter (
        .i_req   (s_arvalid),
        .i_ptr   (r_rr_ptr),
        .o_grant (w_arb_onehot),
        .o_idx   (w_arb_idx)
    );

    assign w_arb_any = |w_arb_onehot;

    always_comb begin
        w_g_arid   = '0;
        m_araddr   = '0;
        m_arlen    = '0;
        m_arsize   = '0;
        m_arburst  = '0;
        w_g_rready = 1'b0;
        for (int unsigned i = 0; i < NUM_MST; i++) begin
            if (r_grant_idx == IDX_W'(i)) begin
                w_g_arid   = s_arid[i*ID_WIDTH +: ID_WIDTH];
                m_araddr   = s_araddr[i*ADDR_WIDTH +: ADDR_WIDTH];
                m_arlen    = s_arlen[i*LEN_WIDTH +: LEN_WIDTH];
                m_arsize   = s_arsize[i*3 +: 3];
                m_arburst  = s_arburst[i*2 +: 2];
                w_g_rready = s_rready[i];
            end
        end
    end

    assign m_arid = {r_grant_idx, w_g_arid};

    always_comb begin
        w_state_nxt = r_state;
        m_arvalid   = 1'b0;
        m_rready    = 1'b0;
        s_arready   = '0;
        s_rvalid    = '0;
        case (r_state)
            IDLE: begin
                if (w_arb_any) w_state_nxt = ADDR;
            end
            ADDR: begin
                m_arvalid = 1'b1;
                for (int unsigned i = 0; i < NUM_MST; i++)
                    if (r_grant_idx == IDX_W'(i)) s_arready[i] = m_arready;
                if (m_arready) w_state_nxt = DATA;
            end
            DATA: begin
                m_rready = w_g_rready;
                for (int unsigned i = 0; i < NUM_MST; i++)
                    if (r_grant_idx == IDX_W'(i)) s_rvalid[i] = m_rvalid;
                if (m_rvalid && w_g_rready && m_rlast) w_state_nxt = IDLE;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    assign w_ar_hs   = (r_state == ADDR) && m_arready;
    assign w_r_hs    = (r_state == DATA) && m_rvalid && w_g_rready;
    assign w_ptr_nxt = (r_grant_idx == IDX_W'(NUM_MST - 1)) ? '0 : r_grant_idx + 1'b1;

    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            r_state     <= IDLE;
            r_rr_ptr    <= '0;
            r_grant_idx <= '0;
            r_beat_cnt  <= '0;
            r_exp_len   <= '0;
            r_err_id    <= 1'b0;
            r_err_len   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if ((r_state == IDLE) && w_arb_any) r_grant_idx <= w_arb_idx;
            if (w_ar_hs) begin
                r_beat_cnt <= '0;
                r_exp_len  <= m_arlen;
            end
            // beat_cnt holds the index of the current beat; RLAST belongs on index ARLEN
            if (w_r_hs) begin
                r_beat_cnt <= r_beat_cnt + 1'b1;
                if (m_rid[ID_WIDTH +: IDX_W] != r_grant_idx) r_err_id <= 1'b1;
                if (m_rlast != (r_beat_cnt == {1'b0, r_exp_len})) r_err_len <= 1'b1;
                if (m_rlast) r_rr_ptr <= w_ptr_nxt;
            end
        end
    end

    assign s_rid     = m_rid[ID_WIDTH-1:0];
    assign s_rdata   = m_rdata;
    assign s_rresp   = m_rresp;
    assign s_rlast   = m_rlast;
    assign busy      = (r_state != IDLE);
    assign grant_idx = r_grant_idx;
    assign err_id    = r_err_id;
    assign err_len   = r_err_len;

endmodule
